// File: rtl/wb_ic_pkg.sv
// Shared types and sizing helpers for the N-slave Wishbone interconnect.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StRelease
  } state_e;

  localparam int unsigned TimeoutDefault = 20;
  localparam int unsigned CntWidthDefault = $clog2(TimeoutDefault + 1);

  // Counter must be able to hold TIMEOUT itself so it can saturate there.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int unsigned sel_width(input int unsigned num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/wishbone_interconnect_n_if.sv
// Bundle of master-side and slave-side bus signals of the N-slave interconnect.
interface wishbone_interconnect_n_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                             m_we_i;
  logic                             m_cyc_i;
  logic                             m_stb_i;
  logic [ADDR_WIDTH-1:0]            m_adr_i;
  logic [DATA_WIDTH-1:0]            m_dat_i;
  logic [DATA_WIDTH-1:0]            m_dat_o;
  logic                             m_ack_o;
  logic                             m_err_o;
  logic                             m_int_o;
  logic [NUM_SLAVES-1:0]            m_int_vec_o;
  logic                             s_we_o;
  logic [ADDR_WIDTH-1:0]            s_adr_o;
  logic [DATA_WIDTH-1:0]            s_dat_o;
  logic [NUM_SLAVES-1:0]            s_cyc_o;
  logic [NUM_SLAVES-1:0]            s_stb_o;
  logic [NUM_SLAVES-1:0]            s_ack_i;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]            s_int_i;

  // Interconnect view: it is the slave of the upstream master.
  modport slave (
    input  m_we_i, m_cyc_i, m_stb_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i, s_int_i,
    output m_dat_o, m_ack_o, m_err_o, m_int_o, m_int_vec_o,
    output s_we_o, s_adr_o, s_dat_o, s_cyc_o, s_stb_o
  );

  // Environment view: upstream master plus the peripherals.
  modport master (
    output m_we_i, m_cyc_i, m_stb_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i, s_int_i,
    input  m_dat_o, m_ack_o, m_err_o, m_int_o, m_int_vec_o,
    input  s_we_o, s_adr_o, s_dat_o, s_cyc_o, s_stb_o
  );

endinterface

// File: rtl/wb_ic_decode.sv
// Address decoder: extracts the slave index, checks it is mapped, and strips the
// index field so slaves see local addresses.
module wb_ic_decode
  import wb_ic_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEL_MSB    = 31,
  parameter int unsigned SEL_LSB    = 24,
  localparam int unsigned IdxWidth  = SEL_MSB - SEL_LSB + 1,
  localparam int unsigned SelWidth  = sel_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] adr_i,
  output logic [SelWidth-1:0]   sel_o,
  output logic                  in_range_o,
  output logic [ADDR_WIDTH-1:0] local_adr_o
);

  logic [IdxWidth-1:0] idx;

  always_comb begin
    idx        = adr_i[SEL_MSB:SEL_LSB];
    in_range_o = (64'(idx) < 64'(NUM_SLAVES));
    // Truncated value is only consumed when in_range_o is set.
    sel_o      = SelWidth'(idx);
    local_adr_o = adr_i;
    local_adr_o[SEL_MSB:SEL_LSB] = '0;
  end

endmodule

// File: rtl/wishbone_interconnect_n.sv
// One-master, N-slave Wishbone interconnect with bus error on unmapped
// addresses, per-transaction timeout, abort on cyc drop and registered IRQs.
module wishbone_interconnect_n
  import wb_ic_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_MSB    = 31,
  parameter int unsigned SEL_LSB    = 24,
  parameter int unsigned TIMEOUT    = 20
) (
  input logic                      clk,
  input logic                      rst,
  wishbone_interconnect_n_if.slave bus
);

  localparam int unsigned CntWidth = cnt_width(TIMEOUT);
  localparam int unsigned SelWidth = sel_width(NUM_SLAVES);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TIMEOUT);

  state_e                state_q;
  logic [SelWidth-1:0]   sel_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  err_q;
  logic [NUM_SLAVES-1:0] int_vec_q;
  logic                  int_q;

  logic [SelWidth-1:0]   dec_sel;
  logic                  dec_in_range;
  logic [ADDR_WIDTH-1:0] local_adr;
  logic                  active;
  logic                  sel_ack;
  logic                  timed_out;

  wb_ic_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .ADDR_WIDTH(ADDR_WIDTH),
    .SEL_MSB   (SEL_MSB),
    .SEL_LSB   (SEL_LSB)
  ) u_decode (
    .adr_i      (bus.m_adr_i),
    .sel_o      (dec_sel),
    .in_range_o (dec_in_range),
    .local_adr_o(local_adr)
  );

  // A dropped cyc suppresses both ack and timeout error in the abort cycle.
  always_comb begin
    active    = (state_q == StActive);
    sel_ack   = active && bus.m_cyc_i && bus.s_ack_i[sel_q];
    timed_out = active && bus.m_cyc_i && !sel_ack && (cnt_q == CntLast);
  end

  always_comb begin
    bus.s_we_o  = bus.m_we_i;
    bus.s_adr_o = local_adr;
    bus.s_dat_o = bus.m_dat_i;
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    bus.m_dat_o = '0;
    if (active) begin
      bus.s_cyc_o[sel_q] = 1'b1;
      bus.s_stb_o[sel_q] = 1'b1;
      bus.m_dat_o        = bus.s_dat_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
    end
    bus.m_ack_o     = sel_ack;
    bus.m_err_o     = err_q | timed_out;
    bus.m_int_o     = int_q;
    bus.m_int_vec_o = int_vec_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      int_vec_q <= '0;
      int_q     <= 1'b0;
    end else begin
      int_vec_q <= bus.s_int_i;
      int_q     <= |bus.s_int_i;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.m_cyc_i && bus.m_stb_i) begin
            if (dec_in_range) begin
              sel_q   <= dec_sel;
              cnt_q   <= '0;
              state_q <= StActive;
            end else begin
              err_q   <= 1'b1;
              state_q <= StRelease;
            end
          end
        end
        StActive: begin
          if (!bus.m_cyc_i) begin
            state_q <= StIdle;
          end else if (sel_ack || timed_out) begin
            state_q <= StRelease;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        // Hold off until stb drops so a held strobe cannot re-issue.
        StRelease: begin
          if (!bus.m_stb_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_interconnect_n.sv
// Self-checking bench for wishbone_interconnect_n: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_wishbone_interconnect_n;

  localparam int NS = 4;
  localparam int TO = 20;
  localparam int Budget = 60;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wishbone_interconnect_n_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wishbone_interconnect_n #(
    .NUM_SLAVES(NS),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SEL_MSB   (31),
    .SEL_LSB   (24),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the last transaction driven by run_xfer.
  int          obs_ack_k, obs_err_k, obs_ack_cnt, obs_err_cnt, obs_post_stb;
  bit          obs_timed_out;
  logic [31:0] obs_data, obs_adr, obs_sdat;
  logic        obs_we;
  logic [3:0]  obs_stb_or;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_master();
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.m_we_i  = 1'b0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_ack_i = '0;
    bus.s_dat_i = '0;
  endtask

  // Drives one master transaction and acts as the addressed slave, acking on
  // its lat-th strobe cycle. Cycle 0 is the cycle the master raises stb.
  task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input int lat, input logic [31:0] rdat, input int hold, input bit noise);
    int tgt, strobes, done_k, idle_run;
    bit m_on;
    tgt = int'(adr[31:24]);
    obs_ack_k = -1; obs_err_k = -1; obs_ack_cnt = 0; obs_err_cnt = 0; obs_post_stb = 0;
    obs_timed_out = 1'b1; obs_data = '0; obs_stb_or = '0;
    strobes = 0; done_k = -1; idle_run = 0;
    for (int k = 0; k < Budget; k++) begin
      m_on = (done_k < 0) || (k - done_k <= hold);
      bus.m_cyc_i = m_on;
      bus.m_stb_i = m_on;
      bus.m_we_i  = we;
      bus.m_adr_i = adr;
      bus.m_dat_i = wdat;
      bus.s_ack_i = noise ? 4'($urandom) : 4'b0;
      for (int s = 0; s < NS; s++) bus.s_dat_i[s*32 +: 32] = $urandom;
      if (tgt < NS) begin
        bus.s_ack_i[tgt] = 1'b0;
        if (bus.s_stb_o[tgt]) begin
          strobes++;
          bus.s_dat_i[tgt*32 +: 32] = rdat;
          if (strobes == lat) bus.s_ack_i[tgt] = 1'b1;
        end
      end
      #1;
      if (k == 0) begin
        obs_adr = bus.s_adr_o; obs_we = bus.s_we_o; obs_sdat = bus.s_dat_o;
      end
      if (done_k >= 0 && bus.s_stb_o != '0) obs_post_stb++;
      obs_stb_or |= bus.s_stb_o;
      if (bus.m_ack_o) begin
        obs_ack_cnt++;
        if (obs_ack_k < 0) begin obs_ack_k = k; obs_data = bus.m_dat_o; end
      end
      if (bus.m_err_o) begin
        obs_err_cnt++;
        if (obs_err_k < 0) obs_err_k = k;
      end
      if (done_k < 0 && (bus.m_ack_o || bus.m_err_o)) done_k = k;
      idle_run = m_on ? 0 : idle_run + 1;
      tick();
      if (idle_run >= 2) begin
        obs_timed_out = 1'b0;
        break;
      end
    end
    idle_master();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_master();
    bus.s_int_i = 4'hf;
    repeat (2) tick();
    checks++; if (bus.s_stb_o !== 4'b0) begin errors++; $display("FAIL reset_stb: got %b want 0000", bus.s_stb_o); end
    checks++; if (bus.s_cyc_o !== 4'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0000", bus.s_cyc_o); end
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b00) begin errors++; $display("FAIL reset_ack_err: got %b want 00", {bus.m_ack_o, bus.m_err_o}); end
    checks++; if (bus.m_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.m_dat_o); end
    checks++; if ({bus.m_int_o, bus.m_int_vec_o} !== 5'b0) begin errors++; $display("FAIL reset_int: got %b want 00000", {bus.m_int_o, bus.m_int_vec_o}); end
    bus.s_int_i = 4'h0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read();
    run_xfer(1'b0, 32'h0100_0004, 32'h0, 2, 32'h0123_4567, 0, 1'b1);
    checks++; if (obs_timed_out) begin errors++; $display("FAIL read_done: got stuck want finished"); end
    checks++; if (obs_adr !== 32'h0000_0004) begin errors++; $display("FAIL read_sadr: got %h want 00000004", obs_adr); end
    checks++; if (obs_stb_or !== 4'b0010) begin errors++; $display("FAIL read_stb: got %b want 0010", obs_stb_or); end
    checks++; if (obs_ack_k !== 2) begin errors++; $display("FAIL read_ack_cycle: got %0d want 2", obs_ack_k); end
    checks++; if (obs_data !== 32'h0123_4567) begin errors++; $display("FAIL read_data: got %h want 01234567", obs_data); end
    checks++; if (obs_err_cnt !== 0) begin errors++; $display("FAIL read_err: got %0d want 0", obs_err_cnt); end
  endtask

  task automatic test_write_hold();
    run_xfer(1'b1, 32'h0200_0010, 32'hA5A5_A5A5, 1 + ($urandom % 4), 32'h0, 3, 1'b1);
    checks++; if (obs_stb_or !== 4'b0100) begin errors++; $display("FAIL write_stb: got %b want 0100", obs_stb_or); end
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL write_we: got %b want 1", obs_we); end
    checks++; if (obs_sdat !== 32'hA5A5_A5A5) begin errors++; $display("FAIL write_sdat: got %h want a5a5a5a5", obs_sdat); end
    checks++; if (obs_adr !== 32'h0000_0010) begin errors++; $display("FAIL write_sadr: got %h want 00000010", obs_adr); end
    checks++; if (obs_ack_cnt !== 1) begin errors++; $display("FAIL write_ack_count: got %0d want 1", obs_ack_cnt); end
    checks++; if (obs_post_stb !== 0) begin errors++; $display("FAIL write_double_issue: got %0d want 0", obs_post_stb); end
  endtask

  task automatic test_unmapped();
    run_xfer(1'b0, 32'h0700_0000, 32'h0, 1, 32'h0, 0, 1'b1);
    checks++; if (obs_err_k !== 1) begin errors++; $display("FAIL unmapped_err_cycle: got %0d want 1", obs_err_k); end
    checks++; if (obs_err_cnt !== 1) begin errors++; $display("FAIL unmapped_err_len: got %0d want 1", obs_err_cnt); end
    checks++; if (obs_stb_or !== 4'b0) begin errors++; $display("FAIL unmapped_stb: got %b want 0000", obs_stb_or); end
    checks++; if (obs_ack_cnt !== 0) begin errors++; $display("FAIL unmapped_ack: got %0d want 0", obs_ack_cnt); end
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 32'h0300_0000, 32'h0, 1000, 32'h0, 0, 1'b0);
    checks++; if (obs_err_k !== TO) begin errors++; $display("FAIL timeout_cycle: got %0d want %0d", obs_err_k, TO); end
    checks++; if (obs_err_cnt !== 1) begin errors++; $display("FAIL timeout_err_len: got %0d want 1", obs_err_cnt); end
    checks++; if (obs_post_stb !== 0) begin errors++; $display("FAIL timeout_stb_drop: got %0d want 0", obs_post_stb); end
    checks++; if (obs_stb_or !== 4'b1000) begin errors++; $display("FAIL timeout_stb: got %b want 1000", obs_stb_or); end
    run_xfer(1'b0, 32'h0000_0020, 32'h0, 3, 32'hDEAD_0000, 0, 1'b0);
    checks++; if (obs_ack_k !== 3) begin errors++; $display("FAIL after_timeout_ack: got %0d want 3", obs_ack_k); end
    checks++; if (obs_data !== 32'hDEAD_0000) begin errors++; $display("FAIL after_timeout_data: got %h want dead0000", obs_data); end
    // Ack landing on the last allowed cycle wins over the timeout.
    run_xfer(1'b0, 32'h0200_0000, 32'h0, TO, 32'h0000_BEEF, 0, 1'b0);
    checks++; if (obs_ack_k !== TO) begin errors++; $display("FAIL ack_vs_timeout_ack: got %0d want %0d", obs_ack_k, TO); end
    checks++; if (obs_err_cnt !== 0) begin errors++; $display("FAIL ack_vs_timeout_err: got %0d want 0", obs_err_cnt); end
  endtask

  task automatic test_abort_and_reset();
    bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0200_0000;
    repeat (4) tick();
    checks++; if (bus.s_stb_o !== 4'b0100) begin errors++; $display("FAIL abort_pre_stb: got %b want 0100", bus.s_stb_o); end
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; bus.s_ack_i = 4'b0100;
    #1;
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b00) begin errors++; $display("FAIL abort_ack_err: got %b want 00", {bus.m_ack_o, bus.m_err_o}); end
    tick();
    bus.s_ack_i = '0;
    checks++; if ({bus.s_cyc_o, bus.s_stb_o} !== 8'b0) begin errors++; $display("FAIL abort_stb_drop: got %b want 0", {bus.s_cyc_o, bus.s_stb_o}); end
    run_xfer(1'b0, 32'h0100_0000, 32'h0, 1, 32'h1111_2222, 0, 1'b0);
    checks++; if (obs_ack_k !== 1) begin errors++; $display("FAIL abort_then_idle: got %0d want 1", obs_ack_k); end
    // Asynchronous reset in the middle of an ACTIVE cycle.
    bus.s_int_i = 4'b0101;
    bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0100_0000;
    bus.s_dat_i = {4{32'hCAFE_F00D}};
    repeat (2) tick();
    bus.s_ack_i = 4'b0010;
    #1;
    checks++; if ({bus.s_stb_o, bus.m_ack_o} !== 5'b0010_1) begin errors++; $display("FAIL prereset_active: got %b want 00101", {bus.s_stb_o, bus.m_ack_o}); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({bus.s_cyc_o, bus.s_stb_o} !== 8'b0) begin errors++; $display("FAIL async_reset_stb: got %b want 0", {bus.s_cyc_o, bus.s_stb_o}); end
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b00) begin errors++; $display("FAIL async_reset_ack: got %b want 00", {bus.m_ack_o, bus.m_err_o}); end
    checks++; if (bus.m_dat_o !== 32'h0) begin errors++; $display("FAIL async_reset_dat: got %h want 0", bus.m_dat_o); end
    checks++; if ({bus.m_int_o, bus.m_int_vec_o} !== 5'b0) begin errors++; $display("FAIL async_reset_int: got %b want 0", {bus.m_int_o, bus.m_int_vec_o}); end
    idle_master();
    bus.s_int_i = '0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_interrupt();
    logic [3:0] v, prev;
    bus.s_int_i = 4'b1000;
    #1;
    checks++; if (bus.m_int_vec_o !== 4'b0000) begin errors++; $display("FAIL int_latency: got %b want 0000", bus.m_int_vec_o); end
    tick();
    checks++; if ({bus.m_int_o, bus.m_int_vec_o} !== 5'b1_1000) begin errors++; $display("FAIL int_set: got %b want 11000", {bus.m_int_o, bus.m_int_vec_o}); end
    bus.s_int_i = 4'b0000;
    tick();
    checks++; if ({bus.m_int_o, bus.m_int_vec_o} !== 5'b0) begin errors++; $display("FAIL int_clear: got %b want 00000", {bus.m_int_o, bus.m_int_vec_o}); end
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      v = 4'($urandom);
      bus.s_int_i = v;
      #1;
      checks++; if (bus.m_int_vec_o !== prev) begin errors++; $display("FAIL int_rand_hold[%0d]: got %b want %b", i, bus.m_int_vec_o, prev); end
      tick();
      checks++; if ({bus.m_int_o, bus.m_int_vec_o} !== {(v != 4'b0), v}) begin errors++; $display("FAIL int_rand[%0d]: got %b want %b", i, {bus.m_int_o, bus.m_int_vec_o}, {(v != 4'b0), v}); end
      prev = v;
    end
    bus.s_int_i = '0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  idx;
    logic [31:0] adr, wdat, rdat, exp_data;
    logic [3:0]  exp_stb;
    logic        we;
    int          lat, hold, exp_ack_k, exp_err_k;
    for (int t = 0; t < 30; t++) begin
      idx  = 8'($urandom_range(0, 7));
      adr  = {idx, 24'($urandom)};
      we   = 1'($urandom);
      wdat = $urandom;
      rdat = $urandom;
      lat  = $urandom_range(1, TO + 4);
      hold = $urandom_range(0, 3);
      // Transaction-level expectation: unmapped -> error next cycle; otherwise
      // ack after the slave latency unless it exceeds the timeout window.
      exp_data = 32'h0;
      if (idx >= NS) begin
        exp_ack_k = -1; exp_err_k = 1; exp_stb = 4'b0;
      end else begin
        exp_stb = 4'b0001 << idx;
        if (lat <= TO) begin
          exp_ack_k = lat; exp_err_k = -1; exp_data = rdat;
        end else begin
          exp_ack_k = -1; exp_err_k = TO;
        end
      end
      run_xfer(we, adr, wdat, lat, rdat, hold, 1'b1);
      checks++; if (obs_adr !== (adr & 32'h00FF_FFFF) || obs_we !== we || obs_sdat !== wdat) begin
        errors++; $display("FAIL rand_bcast[%0d]: got %h/%b/%h want %h/%b/%h", t, obs_adr, obs_we, obs_sdat, adr & 32'h00FF_FFFF, we, wdat);
      end
      checks++; if (obs_ack_k !== exp_ack_k || obs_err_k !== exp_err_k) begin
        errors++; $display("FAIL rand_resp[%0d]: got ack@%0d err@%0d want ack@%0d err@%0d", t, obs_ack_k, obs_err_k, exp_ack_k, exp_err_k);
      end
      checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", t, obs_data, exp_data); end
      checks++; if (obs_stb_or !== exp_stb || obs_post_stb !== 0) begin
        errors++; $display("FAIL rand_stb[%0d]: got %b post=%0d want %b post=0", t, obs_stb_or, obs_post_stb, exp_stb);
      end
      checks++; if (obs_ack_cnt + obs_err_cnt !== 1 || obs_timed_out) begin
        errors++; $display("FAIL rand_single[%0d]: got %0d responses stuck=%b want 1 stuck=0", t, obs_ack_cnt + obs_err_cnt, obs_timed_out);
      end
    end
  endtask

  initial begin
    bus.s_int_i = '0;
    test_reset();
    test_read();
    test_write_hold();
    test_unmapped();
    test_timeout();
    test_abort_and_reset();
    test_interrupt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wishbone_interconnect_n.md
Name: wishbone_interconnect_n

Overview:
- Parametrised successor to the fixed 2-slave Wishbone interconnect: one master, NUM_SLAVES slaves.
- Decodes the slave index from an address bit-field and routes a single transaction to the selected slave.
- Adds behaviour the fixed version lacks: bus-error response for unmapped addresses, per-transaction timeout, clean abort, and a registered interrupt vector.
- Sits between wishbone_master and the peripherals; slot 0 is always device_rom_table.

Parameters:
- NUM_SLAVES, 4: number of slave ports, 1..16.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- SEL_MSB, 31: top bit of the slave-index field.
- SEL_LSB, 24: bottom bit of the slave-index field.
- TIMEOUT, 20: cycles to wait for a slave ack before erroring.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- m_we_i  in  1  master write enable.
- m_cyc_i  in  1  master cycle.
- m_stb_i  in  1  master strobe.
- m_adr_i  in  ADDR_WIDTH  master address.
- m_dat_i  in  DATA_WIDTH  master write data.
- m_dat_o  out  DATA_WIDTH  read data to master.
- m_ack_o  out  1  transaction acknowledge.
- m_err_o  out  1  transaction error (unmapped slave or timeout).
- m_int_o  out  1  OR of all slave interrupts, registered.
- m_int_vec_o  out  NUM_SLAVES  per-slave interrupt, registered.
- s_we_o  out  1  write enable, broadcast to all slaves.
- s_adr_o  out  ADDR_WIDTH  master address with SEL field zeroed, broadcast.
- s_dat_o  out  DATA_WIDTH  master write data, broadcast.
- s_cyc_o  out  NUM_SLAVES  one-hot cycle.
- s_stb_o  out  NUM_SLAVES  one-hot strobe.
- s_ack_i  in  NUM_SLAVES  slave acks.
- s_dat_i  in  NUM_SLAVES*DATA_WIDTH  slave read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_int_i  in  NUM_SLAVES  slave interrupts.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, sel=0, timeout counter=0, m_int_o=0, m_int_vec_o=0. All of s_cyc_o, s_stb_o, m_ack_o, m_err_o are 0; m_dat_o=0.
- State machine: IDLE, ACTIVE, RELEASE.
- IDLE, m_cyc_i & m_stb_i high:
  - idx = m_adr_i[SEL_MSB:SEL_LSB].
  - idx < NUM_SLAVES: register sel=idx, clear counter, go ACTIVE.
  - Otherwise: m_err_o=1 for exactly one cycle (the next cycle), m_dat_o=0, go RELEASE.
- ACTIVE:
  - s_cyc_o[sel] and s_stb_o[sel] are 1; all other bits are 0. Slave sees its strobe one cycle after master strobe.
  - m_dat_o = slice sel of s_dat_i (combinational).
  - m_ack_o = s_ack_i[sel] (combinational, same cycle).
  - On ack: go RELEASE; the slave strobe drops the next cycle.
  - Counter increments each cycle without ack. When counter reaches TIMEOUT-1 with no ack: m_err_o=1 for one cycle, drop the slave strobe, go RELEASE.
  - m_cyc_i falling: abort to IDLE next cycle, no ack/err, slave strobe dropped.
- RELEASE: all slave strobes 0; wait for m_stb_i=0, then IDLE. This prevents double issue when the master holds stb.
- Acks from non-selected slaves are ignored; simultaneous ack and timeout on the same cycle resolves as ack.
- s_we_o, s_adr_o, s_dat_o are combinational from the master in every state. The SEL field is zeroed so a slave sees local addresses.
- Interrupts: m_int_vec_o <= s_int_i each cycle; m_int_o <= |s_int_i. One cycle latency, independent of state.
- Counter width is $clog2(TIMEOUT+1) and saturates; it does not wrap.

Decomposition:
- Shared package wb_ic_pkg: state enum (IDLE, ACTIVE, RELEASE) and a localparam for counter width.
- Sub-module wb_ic_decode: combinational idx extraction, in-range check, and address masking. The FSM, counter and mux stay in the top.

Test Plan:
- NUM_SLAVES=4. Read 0x01000004 with slave 1 acking on its 2nd strobe cycle returning 0x01234567 -> s_adr_o=0x00000004; s_stb_o=4'b0010; m_ack_o=1 with m_dat_o=0x01234567; no other slave strobed.
- Write 0x02000010 data 0xA5A5A5A5 -> s_stb_o=4'b0100, s_we_o=1, s_dat_o=0xA5A5A5A5; after ack, holding m_stb_i 3 extra cycles produces no second strobe.
- Access 0x07000000 -> m_err_o single-cycle pulse one cycle after strobe; no s_stb_o bit set; m_ack_o stays 0.
- Slave 3 never acks, TIMEOUT=20 -> m_err_o pulses on the 20th ACTIVE cycle; s_stb_o[3] is 0 from the next cycle; a following transaction to slave 0 completes normally.
- Drop m_cyc_i mid-ACTIVE -> IDLE next cycle with no ack/err; then assert rst low mid-transaction -> all outputs 0 immediately, without waiting for a clock edge.
- s_int_i=4'b1000 -> m_int_vec_o=4'b1000 and m_int_o=1 one cycle later; both clear one cycle after the input clears.
